// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, writeback/ALU encodings, ID/EX control bundle.
// Width-parameterised fields (pc, imm) live beside the bundle, not inside it.
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [3:0] alu_sel;
        logic       b_sel;
        logic       a_pc_sel;
        logic       shamt_sel;
        logic [1:0] wb_sel;
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        logic       unsign;
        logic       is_branch;
        logic       is_jump;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/rv_decoder.sv
// RV32I instruction decoder: inst -> control bundle, immediate, source-use flags.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module rv_decoder
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            use1,
    output logic            use2,
    output logic            is_ecall
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm32;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign is_ecall = (inst == INST_ECALL);

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign imm = XLEN'($signed(imm32));

    always_comb begin
        ctrl           = '0;
        ctrl.rs1       = inst[19:15];
        ctrl.rs2       = inst[24:20];
        ctrl.rd        = inst[11:7];
        ctrl.funct3    = funct3;
        ctrl.alu_sel   = ALU_ADD;
        ctrl.wb_sel    = WB_ALU;
        imm32          = 32'd0;
        use1           = 1'b0;
        use2           = 1'b0;

        case (opcode)
            OPC_LUI: begin
                // rs1 forced to x0 so the ALU computes 0 + imm
                ctrl.rs1    = 5'd0;
                ctrl.b_sel  = 1'b1;
                ctrl.reg_we = 1'b1;
                imm32       = imm_u;
            end
            OPC_AUIPC: begin
                ctrl.a_pc_sel = 1'b1;
                ctrl.b_sel    = 1'b1;
                ctrl.reg_we   = 1'b1;
                imm32         = imm_u;
            end
            OPC_JAL: begin
                ctrl.a_pc_sel = 1'b1;
                ctrl.b_sel    = 1'b1;
                ctrl.wb_sel   = WB_PC4;
                ctrl.reg_we   = 1'b1;
                ctrl.is_jump  = 1'b1;
                imm32         = imm_j;
            end
            OPC_JALR: begin
                ctrl.b_sel   = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                ctrl.reg_we  = 1'b1;
                ctrl.is_jump = 1'b1;
                imm32        = imm_i;
                use1         = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.is_branch = 1'b1;
                ctrl.unsign    = funct3[1];
                imm32          = imm_b;
                use1           = 1'b1;
                use2           = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.b_sel  = 1'b1;
                ctrl.wb_sel = WB_MEM;
                ctrl.reg_we = 1'b1;
                ctrl.mem_re = 1'b1;
                ctrl.unsign = funct3[2];
                imm32       = imm_i;
                use1        = 1'b1;
            end
            OPC_STORE: begin
                ctrl.b_sel  = 1'b1;
                ctrl.mem_we = 1'b1;
                imm32       = imm_s;
                use1        = 1'b1;
                use2        = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.b_sel     = 1'b1;
                ctrl.reg_we    = 1'b1;
                ctrl.shamt_sel = (funct3 == 3'b001) || (funct3 == 3'b101);
                ctrl.alu_sel   = {(funct3 == 3'b101) & inst[30], funct3};
                ctrl.unsign    = (funct3 == 3'b011);
                imm32          = imm_i;
                use1           = 1'b1;
            end
            OPC_OP: begin
                ctrl.reg_we  = 1'b1;
                ctrl.alu_sel = {((funct3 == 3'b000) || (funct3 == 3'b101)) & inst[30], funct3};
                ctrl.unsign  = (funct3 == 3'b011);
                use1         = 1'b1;
                use2         = 1'b1;
            end
            OPC_SYSTEM: begin
                // ECALL and other SYSTEM words issue as side-effect-free NOPs
                imm32 = imm_i;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase

        if (ctrl.rd == 5'd0) begin
            ctrl.reg_we = 1'b0;
        end
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// RV32I decode/control stage holding the ID/EX register, load-use bubbles and ECALL halt.
// Latency: one cycle from accepted if_inst to ex_* outputs.
// Backpressure: ex_ready=0 holds ID/EX; id_ready drops on hazard, halt, flush or stall.
module id_ctrl_stage
    import rv_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int PC_W          = 32,
    parameter int CNT_W         = 16,
    parameter bit HALT_ON_ECALL = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             if_valid,
    input  logic [31:0]      if_inst,
    input  logic [PC_W-1:0]  if_pc,
    output logic             id_ready,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             ex_valid,
    output logic [PC_W-1:0]  ex_pc,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic [XLEN-1:0]  ex_imm,
    output logic [3:0]       ex_alu_sel,
    output logic             ex_b_sel,
    output logic             ex_a_pc_sel,
    output logic             ex_shamt_sel,
    output logic [1:0]       ex_wb_sel,
    output logic             ex_reg_we,
    output logic             ex_mem_we,
    output logic             ex_mem_re,
    output logic             ex_unsign,
    output logic             ex_is_branch,
    output logic             ex_is_jump,
    output logic             ex_illegal,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    ctrl_t             dec_ctrl;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_use1;
    logic              dec_use2;
    logic              dec_ecall;

    ctrl_t             ex_ctrl_q;
    logic              ex_valid_q;
    logic [PC_W-1:0]   ex_pc_q;
    logic [XLEN-1:0]   ex_imm_q;
    logic [0:0]        state_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              hz;

    rv_decoder #(.XLEN(XLEN)) u_dec (
        .inst     (if_inst),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .use1     (dec_use1),
        .use2     (dec_use2),
        .is_ecall (dec_ecall)
    );

    // Load in ID/EX whose result a younger instruction needs one cycle too early
    assign hz = ex_valid_q & ex_ctrl_q.mem_re & (ex_ctrl_q.rd != 5'd0) &
                (((ex_ctrl_q.rd == dec_ctrl.rs1) & dec_use1) |
                 ((ex_ctrl_q.rd == dec_ctrl.rs2) & dec_use2));

    assign halted   = (state_q == ST_HALT);
    assign id_ready = ex_ready & ~hz & ~halted & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_pc_q     <= '0;
            ex_imm_q    <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (ex_ready) begin
            if (hz && if_valid) begin
                ex_valid_q <= 1'b0;
                if (stall_cnt_q != {CNT_W{1'b1}}) begin
                    stall_cnt_q <= stall_cnt_q + 1'b1;
                end
            end else begin
                ex_valid_q <= if_valid & ~halted;
                ex_ctrl_q  <= dec_ctrl;
                ex_pc_q    <= if_pc;
                ex_imm_q   <= dec_imm;
                if (HALT_ON_ECALL && if_valid && !halted && dec_ecall) begin
                    state_q <= ST_HALT;
                end
            end
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs1       = ex_ctrl_q.rs1;
    assign ex_rs2       = ex_ctrl_q.rs2;
    assign ex_rd        = ex_ctrl_q.rd;
    assign ex_funct3    = ex_ctrl_q.funct3;
    assign ex_alu_sel   = ex_ctrl_q.alu_sel;
    assign ex_b_sel     = ex_ctrl_q.b_sel;
    assign ex_a_pc_sel  = ex_ctrl_q.a_pc_sel;
    assign ex_shamt_sel = ex_ctrl_q.shamt_sel;
    assign ex_wb_sel    = ex_ctrl_q.wb_sel;
    assign ex_reg_we    = ex_ctrl_q.reg_we;
    assign ex_mem_we    = ex_ctrl_q.mem_we;
    assign ex_mem_re    = ex_ctrl_q.mem_re;
    assign ex_unsign    = ex_ctrl_q.unsign;
    assign ex_is_branch = ex_ctrl_q.is_branch;
    assign ex_is_jump   = ex_ctrl_q.is_jump;
    assign ex_illegal   = ex_ctrl_q.illegal;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: decode, load-use bubbles, flush, backpressure, ECALL halt.
module tb_id_ctrl_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_imm;
    logic [3:0]  ex_alu_sel;
    logic        ex_b_sel, ex_a_pc_sel, ex_shamt_sel;
    logic [1:0]  ex_wb_sel;
    logic        ex_reg_we, ex_mem_we, ex_mem_re, ex_unsign;
    logic        ex_is_branch, ex_is_jump, ex_illegal;
    logic        halted;
    logic [15:0] stall_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    id_ctrl_stage dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .ex_ready     (ex_ready),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_funct3    (ex_funct3),
        .ex_imm       (ex_imm),
        .ex_alu_sel   (ex_alu_sel),
        .ex_b_sel     (ex_b_sel),
        .ex_a_pc_sel  (ex_a_pc_sel),
        .ex_shamt_sel (ex_shamt_sel),
        .ex_wb_sel    (ex_wb_sel),
        .ex_reg_we    (ex_reg_we),
        .ex_mem_we    (ex_mem_we),
        .ex_mem_re    (ex_mem_re),
        .ex_unsign    (ex_unsign),
        .ex_is_branch (ex_is_branch),
        .ex_is_jump   (ex_is_jump),
        .ex_illegal   (ex_illegal),
        .halted       (halted),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        if_valid = 1'b0;
        if_inst  = 32'h0;
        if_pc    = 32'h0;
        ex_ready = 1'b1;
        flush    = 1'b0;
        #12;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_reg_we", ex_reg_we, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // addi x5,x0,7
        drive(1'b1, 32'h00700293, 32'h100);
        chk("addi_id_ready", id_ready, 1);
        tick();
        chk("addi_valid", ex_valid, 1);
        chk("addi_rd", ex_rd, 5);
        chk("addi_imm", ex_imm, 7);
        chk("addi_b_sel", ex_b_sel, 1);
        chk("addi_wb_sel", ex_wb_sel, 1);
        chk("addi_reg_we", ex_reg_we, 1);
        chk("addi_pc", ex_pc, 32'h100);

        // lw x6,0(x5) then add x7,x6,x6: one bubble
        drive(1'b1, 32'h0002A303, 32'h104);
        tick();
        chk("lw_mem_re", ex_mem_re, 1);
        chk("lw_rd", ex_rd, 6);
        chk("lw_wb_sel", ex_wb_sel, 0);
        drive(1'b1, 32'h006303B3, 32'h108);
        chk("lu_id_ready_low", id_ready, 0);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_id_ready_back", id_ready, 1);
        tick();
        chk("add_valid", ex_valid, 1);
        chk("add_rd", ex_rd, 7);
        chk("add_rs1", ex_rs1, 6);
        chk("add_rs2", ex_rs2, 6);
        chk("add_b_sel", ex_b_sel, 0);
        chk("add_pc", ex_pc, 32'h108);

        // lw x0,0(x5) then add x7,x6,x6: no bubble
        drive(1'b1, 32'h0002A003, 32'h10C);
        tick();
        chk("lw0_reg_we", ex_reg_we, 0);
        drive(1'b1, 32'h006303B3, 32'h110);
        chk("lw0_id_ready", id_ready, 1);
        tick();
        chk("lw0_add_valid", ex_valid, 1);
        chk("lw0_add_rd", ex_rd, 7);
        chk("lw0_stall_cnt", stall_cnt, 1);

        // sub x9,x1,x2
        drive(1'b1, 32'h402084B3, 32'h114);
        tick();
        chk("sub_alu_sel", ex_alu_sel, 4'b1000);

        // lui x10,0x80008 with nonzero rs1 field
        drive(1'b1, 32'h80008537, 32'h118);
        tick();
        chk("lui_imm", ex_imm, 32'h80008000);
        chk("lui_rs1", ex_rs1, 0);
        chk("lui_a_pc_sel", ex_a_pc_sel, 0);

        // beq x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 32'h11C);
        tick();
        chk("beq_branch", ex_is_branch, 1);
        chk("beq_imm", ex_imm, 32'hFFFFFFFC);
        chk("beq_reg_we", ex_reg_we, 0);

        // flush with a valid instruction present
        drive(1'b1, 32'h00700293, 32'h120);
        flush = 1'b1;
        #1;
        chk("flush_id_ready", id_ready, 0);
        tick();
        chk("flush_valid", ex_valid, 0);
        flush = 1'b0;

        // jal x1,+8
        drive(1'b1, 32'h008000EF, 32'h124);
        tick();
        chk("jal_imm", ex_imm, 8);
        chk("jal_is_jump", ex_is_jump, 1);
        chk("jal_a_pc_sel", ex_a_pc_sel, 1);
        chk("jal_wb_sel", ex_wb_sel, 2);
        chk("jal_rd", ex_rd, 1);

        // backpressure: addi issued, then 3 stalled cycles with addi x8,x0,3 waiting
        drive(1'b1, 32'h00700293, 32'h200);
        tick();
        drive(1'b1, 32'h00300413, 32'h204);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_ready", id_ready, 0);
            tick();
            chk("bp_hold_rd", ex_rd, 5);
            chk("bp_hold_imm", ex_imm, 7);
            chk("bp_hold_pc", ex_pc, 32'h200);
            chk("bp_hold_valid", ex_valid, 1);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_id_ready_back", id_ready, 1);
        tick();
        chk("bp_new_rd", ex_rd, 8);
        chk("bp_new_imm", ex_imm, 3);
        chk("bp_new_pc", ex_pc, 32'h204);

        // ECALL together with flush: flush wins, no halt
        drive(1'b1, 32'h00000073, 32'h208);
        flush = 1'b1;
        tick();
        chk("ecall_flush_valid", ex_valid, 0);
        chk("ecall_flush_halted", halted, 0);
        flush = 1'b0;

        // illegal opcode
        drive(1'b1, 32'h0000007F, 32'h20C);
        tick();
        chk("ill_flag", ex_illegal, 1);
        chk("ill_valid", ex_valid, 1);
        chk("ill_reg_we", ex_reg_we, 0);
        chk("ill_halted", halted, 0);

        // ECALL proper
        drive(1'b1, 32'h00000073, 32'h210);
        chk("ecall_id_ready", id_ready, 1);
        tick();
        chk("ecall_valid", ex_valid, 1);
        chk("ecall_reg_we", ex_reg_we, 0);
        chk("ecall_mem_we", ex_mem_we, 0);
        chk("ecall_halted", halted, 1);
        drive(1'b1, 32'h00700293, 32'h214);
        chk("halt_id_ready", id_ready, 0);
        tick();
        chk("halt_no_issue", ex_valid, 0);
        chk("halt_persist", halted, 1);
        chk("halt_id_ready2", id_ready, 0);

        // asynchronous reset mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_halted", halted, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_valid", ex_valid, 0);
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
